// File: rtl/ahbl_excl_monitor.sv
// AHB-Lite exclusive-access monitor: keeps one reservation per master, answers
// failing exclusive stores locally and drives HEXOKAY for the data phase.
module ahbl_excl_monitor #(
  parameter int N_MASTERS    = 4,
  parameter int W_ADDR       = 32,
  parameter int W_DATA       = 32,
  parameter int GRANULE_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_hready,
  output logic              src_hready_resp,
  output logic              src_hresp,
  input  logic [W_ADDR-1:0] src_haddr,
  input  logic              src_hwrite,
  input  logic [1:0]        src_htrans,
  input  logic [2:0]        src_hsize,
  input  logic [2:0]        src_hburst,
  input  logic [3:0]        src_hprot,
  input  logic              src_hmastlock,
  input  logic [W_DATA-1:0] src_hwdata,
  output logic [W_DATA-1:0] src_hrdata,
  input  logic              src_hexcl,
  input  logic [7:0]        src_hmaster,
  output logic              src_hexokay,
  output logic              dst_hready,
  input  logic              dst_hready_resp,
  input  logic              dst_hresp,
  output logic [W_ADDR-1:0] dst_haddr,
  output logic              dst_hwrite,
  output logic [1:0]        dst_htrans,
  output logic [2:0]        dst_hsize,
  output logic [2:0]        dst_hburst,
  output logic [3:0]        dst_hprot,
  output logic              dst_hmastlock,
  output logic [W_DATA-1:0] dst_hwdata,
  input  logic [W_DATA-1:0] dst_hrdata
);

  localparam int         W_TAG = W_ADDR - GRANULE_LOG2;
  localparam int         IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam logic [8:0] N_M9  = 9'(N_MASTERS);

  logic [N_MASTERS-1:0] res_v;
  logic [W_TAG-1:0]     res_tag [N_MASTERS];

  logic             dp_act;
  logic             dp_excl;
  logic             dp_write;
  logic             dp_fail;
  logic [IDX_W-1:0] dp_mst;
  logic [W_TAG-1:0] dp_tag;

  logic             addr_acc;
  logic             mst_ok;
  logic [IDX_W-1:0] a_idx;
  logic [W_TAG-1:0] a_tag;
  logic             a_excl;
  logic             ok_done;
  logic             wr_done;
  logic             rd_done;
  logic             clr_hit;
  logic             excl_wr;
  logic             excl_pass;
  logic             excl_fail;

  assign addr_acc = src_hready && src_htrans[1];
  assign mst_ok   = {1'b0, src_hmaster} < N_M9;
  assign a_idx    = src_hmaster[IDX_W-1:0];
  assign a_tag    = src_haddr[W_ADDR-1:GRANULE_LOG2];
  assign a_excl   = src_hexcl && (src_hburst == 3'b000) && mst_ok;

  assign ok_done  = dp_act && !dp_fail && dst_hready_resp && !dst_hresp;
  assign wr_done  = ok_done && dp_write;
  assign rd_done  = ok_done && dp_excl && !dp_write;

  // A write completing this cycle to the same granule must kill the pass
  // decision now, since the table itself only updates at the edge.
  assign clr_hit   = wr_done && (dp_tag == a_tag);
  assign excl_wr   = addr_acc && a_excl && src_hwrite;
  assign excl_pass = res_v[a_idx] && (res_tag[a_idx] == a_tag) && !clr_hit;
  assign excl_fail = excl_wr && !excl_pass;

  assign dst_hready    = src_hready;
  assign dst_haddr     = src_haddr;
  assign dst_hwrite    = src_hwrite;
  assign dst_htrans    = excl_fail ? 2'b00 : src_htrans;
  assign dst_hsize     = src_hsize;
  assign dst_hburst    = src_hburst;
  assign dst_hprot     = src_hprot;
  assign dst_hmastlock = src_hmastlock;
  assign dst_hwdata    = src_hwdata;

  assign src_hready_resp = dp_fail ? 1'b1 : dst_hready_resp;
  assign src_hresp       = dp_fail ? 1'b0 : dst_hresp;
  assign src_hrdata      = dst_hrdata;
  assign src_hexokay     = dp_act && dp_excl && !dp_fail && !dst_hresp;

  // Reservation valid bits; the own-clear of an exclusive write is applied last
  // so it always leaves that master without a reservation.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_v <= '0;
    end else begin
      for (int k = 0; k < N_MASTERS; k++) begin
        if (wr_done && (res_tag[k] == dp_tag)) res_v[k] <= 1'b0;
      end
      if (rd_done) res_v[dp_mst] <= 1'b1;
      if (excl_wr) res_v[a_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rd_done) res_tag[dp_mst] <= dp_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_act   <= 1'b0;
      dp_excl  <= 1'b0;
      dp_write <= 1'b0;
      dp_fail  <= 1'b0;
      dp_mst   <= '0;
      dp_tag   <= '0;
    end else if (addr_acc) begin
      dp_act   <= 1'b1;
      dp_excl  <= a_excl;
      dp_write <= src_hwrite;
      dp_fail  <= excl_fail;
      dp_mst   <= a_idx;
      dp_tag   <= a_tag;
    end else if (src_hready) begin
      dp_act  <= 1'b0;
      dp_fail <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ahbl_excl_monitor.sv
// Bench for ahbl_excl_monitor: directed vector table, a mid-transfer reset
// sequence and randomized traffic against a transaction-level reservation model.
module tb_ahbl_excl_monitor;

  logic        clk;
  logic        rst;
  logic        src_hready;
  logic        src_hready_resp;
  logic        src_hresp;
  logic [31:0] src_haddr;
  logic        src_hwrite;
  logic [1:0]  src_htrans;
  logic [2:0]  src_hsize;
  logic [2:0]  src_hburst;
  logic [3:0]  src_hprot;
  logic        src_hmastlock;
  logic [31:0] src_hwdata;
  logic [31:0] src_hrdata;
  logic        src_hexcl;
  logic [7:0]  src_hmaster;
  logic        src_hexokay;
  logic        dst_hready;
  logic        dst_hready_resp;
  logic        dst_hresp;
  logic [31:0] dst_haddr;
  logic        dst_hwrite;
  logic [1:0]  dst_htrans;
  logic [2:0]  dst_hsize;
  logic [2:0]  dst_hburst;
  logic [3:0]  dst_hprot;
  logic        dst_hmastlock;
  logic [31:0] dst_hwdata;
  logic [31:0] dst_hrdata;

  int tests_run;
  int tests_failed;

  ahbl_excl_monitor dut (
    .clk(clk), .rst(rst),
    .src_hready(src_hready), .src_hready_resp(src_hready_resp), .src_hresp(src_hresp),
    .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans),
    .src_hsize(src_hsize), .src_hburst(src_hburst), .src_hprot(src_hprot),
    .src_hmastlock(src_hmastlock), .src_hwdata(src_hwdata), .src_hrdata(src_hrdata),
    .src_hexcl(src_hexcl), .src_hmaster(src_hmaster), .src_hexokay(src_hexokay),
    .dst_hready(dst_hready), .dst_hready_resp(dst_hready_resp), .dst_hresp(dst_hresp),
    .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans),
    .dst_hsize(dst_hsize), .dst_hburst(dst_hburst), .dst_hprot(dst_hprot),
    .dst_hmastlock(dst_hmastlock), .dst_hwdata(dst_hwdata), .dst_hrdata(dst_hrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [1:0]  tr;
    logic        wr;
    logic        ex;
    logic [7:0]  mst;
    logic [31:0] addr;
    logic [2:0]  burst;
    logic        sr;
    logic        se;
    logic [1:0]  e_tr;
    logic        e_rdy;
    logic        e_resp;
    logic        e_ok;
  } vec_t;

  typedef struct {
    int          mst;
    int unsigned gran;
    bit          write;
    bit          excl;
    bit          lfail;
  } txn_t;

  vec_t        vecs[$];
  txn_t        inflight[$];
  int unsigned resv[int];

  function automatic vec_t mk(input logic r, rd, input logic [1:0] tr, input logic wr, ex,
                              input logic [7:0] mst, input logic [31:0] addr,
                              input logic [2:0] burst, input logic sr, se,
                              input logic [1:0] etr, input logic erdy, eresp, eok);
    vec_t v;
    v.rst = r;  v.rdy = rd; v.tr = tr; v.wr = wr; v.ex = ex; v.mst = mst;
    v.addr = addr; v.burst = burst; v.sr = sr; v.se = se;
    v.e_tr = etr; v.e_rdy = erdy; v.e_resp = eresp; v.e_ok = eok;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    rst             = v.rst;
    src_hready      = v.rdy;
    src_htrans      = v.tr;
    src_hwrite      = v.wr;
    src_hexcl       = v.ex;
    src_hmaster     = v.mst;
    src_haddr       = v.addr;
    src_hburst      = v.burst;
    src_hsize       = 3'b010;
    src_hprot       = 4'b0011;
    src_hmastlock   = 1'b0;
    src_hwdata      = $urandom;
    dst_hready_resp = v.sr;
    dst_hresp       = v.se;
    dst_hrdata      = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  logic [7:0]  mlist [6] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd9};
  logic [31:0] alist [4] = '{32'h1000, 32'h1002, 32'h1004, 32'h2000};

  initial begin : main
    bit          have, lf, fwd, accept, is_ex, pass, wr_done, ok_done, e_ok;
    bit          err_stage;
    int unsigned gran;
    int          m;
    int          keys[$];
    txn_t        t;
    localparam logic [1:0] I = 2'b00;
    localparam logic [1:0] N = 2'b10;

    tests_run    = 0;
    tests_failed = 0;

    // rst rdy tr wr ex mst addr burst sr se | e_tr e_rdy e_resp e_ok
    vecs.push_back(mk(1, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(1, 0, I, 0, 0, 0, 32'h0,    0, 0, 1, I, 0, 1, 0));
    vecs.push_back(mk(0, 1, N, 0, 1, 1, 32'h1000, 0, 1, 0, N, 1, 0, 0));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 1));
    vecs.push_back(mk(0, 1, N, 1, 1, 1, 32'h1000, 0, 1, 0, N, 1, 0, 0));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 1));
    vecs.push_back(mk(0, 1, N, 1, 1, 1, 32'h1000, 0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 0, 1, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, N, 0, 1, 0, 32'h2000, 0, 1, 0, N, 1, 0, 0));
    vecs.push_back(mk(0, 1, N, 1, 0, 1, 32'h2004, 0, 1, 0, N, 1, 0, 1));
    vecs.push_back(mk(0, 1, N, 1, 1, 0, 32'h2000, 0, 1, 0, N, 1, 0, 0));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 1));
    vecs.push_back(mk(0, 1, N, 0, 1, 0, 32'h2000, 0, 1, 0, N, 1, 0, 0));
    vecs.push_back(mk(0, 1, N, 1, 0, 1, 32'h2000, 0, 1, 0, N, 1, 0, 1));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, N, 1, 1, 0, 32'h2000, 0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, N, 0, 1, 0, 32'h3000, 0, 1, 0, N, 1, 0, 0));
    vecs.push_back(mk(0, 1, N, 1, 0, 1, 32'h3000, 0, 1, 0, N, 1, 0, 1));
    vecs.push_back(mk(0, 1, N, 1, 1, 0, 32'h3000, 0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, N, 0, 1, 2, 32'h4000, 0, 1, 0, N, 1, 0, 0));
    vecs.push_back(mk(0, 0, I, 0, 0, 0, 32'h0,    0, 0, 1, I, 0, 1, 0));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 1, I, 1, 1, 0));
    vecs.push_back(mk(0, 1, N, 1, 1, 2, 32'h4000, 0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, N, 0, 1, 0, 32'h5000, 0, 1, 0, N, 1, 0, 0));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 1));
    vecs.push_back(mk(1, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, N, 1, 1, 0, 32'h5000, 0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, N, 0, 1, 3, 32'h6000, 0, 1, 0, N, 1, 0, 0));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 1));
    vecs.push_back(mk(0, 1, N, 1, 1, 3, 32'h6000, 0, 1, 0, N, 1, 0, 0));
    vecs.push_back(mk(0, 0, I, 0, 0, 0, 32'h0,    0, 0, 0, I, 0, 0, 1));
    vecs.push_back(mk(0, 0, I, 0, 0, 0, 32'h0,    0, 0, 0, I, 0, 0, 1));
    vecs.push_back(mk(0, 0, I, 0, 0, 0, 32'h0,    0, 0, 0, I, 0, 0, 1));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 1));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, N, 0, 1, 9, 32'h6000, 0, 1, 0, N, 1, 0, 0));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, N, 1, 1, 9, 32'h6000, 0, 1, 0, N, 1, 0, 0));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, N, 0, 1, 1, 32'h7000, 1, 1, 0, N, 1, 0, 0));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, N, 1, 1, 1, 32'h7000, 0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, N, 0, 1, 2, 32'h8000, 0, 1, 0, N, 1, 0, 0));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 1));
    vecs.push_back(mk(0, 1, N, 1, 1, 2, 32'h8004, 0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, N, 1, 1, 2, 32'h8000, 0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 0));
    vecs.push_back(mk(0, 1, N, 0, 1, 1, 32'h9000, 0, 1, 0, N, 1, 0, 0));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 1));
    vecs.push_back(mk(0, 1, N, 1, 1, 1, 32'h9002, 0, 1, 0, N, 1, 0, 0));
    vecs.push_back(mk(0, 1, I, 0, 0, 0, 32'h0,    0, 1, 0, I, 1, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("vec%0d dst_htrans", i), 32'(dst_htrans), 32'(vecs[i].e_tr));
      check_output($sformatf("vec%0d hready_resp", i), 32'(src_hready_resp), 32'(vecs[i].e_rdy));
      check_output($sformatf("vec%0d hresp", i), 32'(src_hresp), 32'(vecs[i].e_resp));
      check_output($sformatf("vec%0d hexokay", i), 32'(src_hexokay), 32'(vecs[i].e_ok));
    end

    // Reset arriving while an exclusive read is in its data phase.
    @(negedge clk);
    apply_stimulus(mk(0, 1, N, 0, 1, 0, 32'h5000, 0, 1, 0, N, 1, 0, 0));
    @(negedge clk);
    apply_stimulus(mk(1, 1, I, 0, 0, 0, 32'h0, 0, 1, 0, I, 1, 0, 0));
    @(negedge clk);
    apply_stimulus(mk(0, 1, I, 0, 0, 0, 32'h0, 0, 1, 0, I, 1, 0, 0));
    #1;
    check_output("mid_rst hexokay", 32'(src_hexokay), 32'd0);
    check_output("mid_rst hready_resp", 32'(src_hready_resp), 32'd1);
    @(negedge clk);
    apply_stimulus(mk(0, 1, N, 1, 1, 0, 32'h5000, 0, 1, 0, I, 1, 0, 0));
    #1;
    check_output("mid_rst excl_wr dst_htrans", 32'(dst_htrans), 32'd0);
    @(negedge clk);
    apply_stimulus(mk(0, 1, I, 0, 0, 0, 32'h0, 0, 0, 0, I, 1, 0, 0));
    #1;
    check_output("mid_rst local hready_resp", 32'(src_hready_resp), 32'd1);
    check_output("mid_rst local hexokay", 32'(src_hexokay), 32'd0);

    @(negedge clk);
    apply_stimulus(mk(1, 1, I, 0, 0, 0, 32'h0, 0, 1, 0, I, 1, 0, 0));
    resv.delete();
    inflight.delete();
    err_stage = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst  = 1'b0;
      have = inflight.size() != 0;
      lf   = have && inflight[0].lfail;
      fwd  = have && !lf;
      if (!fwd) begin
        dst_hready_resp = 1'b1; dst_hresp = 1'b0; err_stage = 1'b0;
      end else if (err_stage) begin
        dst_hready_resp = 1'b1; dst_hresp = 1'b1; err_stage = 1'b0;
      end else begin
        m = $urandom_range(0, 9);
        if (m < 2)       begin dst_hready_resp = 1'b0; dst_hresp = 1'b0; end
        else if (m == 2) begin dst_hready_resp = 1'b0; dst_hresp = 1'b1; err_stage = 1'b1; end
        else             begin dst_hready_resp = 1'b1; dst_hresp = 1'b0; end
      end
      src_hready    = lf ? 1'b1 : dst_hready_resp;
      src_htrans    = ($urandom_range(0, 9) < 7) ? 2'b10 : 2'b00;
      src_hwrite    = 1'($urandom_range(0, 1));
      src_hexcl     = $urandom_range(0, 9) < 6;
      src_hmaster   = mlist[$urandom_range(0, 5)];
      src_haddr     = alist[$urandom_range(0, 3)];
      src_hburst    = ($urandom_range(0, 9) == 0) ? 3'b001 : 3'b000;
      src_hsize     = 3'($urandom_range(0, 2));
      src_hprot     = 4'($urandom);
      src_hmastlock = 1'($urandom_range(0, 1));
      src_hwdata    = $urandom;
      dst_hrdata    = $urandom;
      #1;

      gran    = src_haddr >> 2;
      m       = int'(src_hmaster);
      is_ex   = src_hexcl && src_hburst == 3'b000 && m < 4;
      ok_done = fwd && dst_hready_resp && !dst_hresp;
      wr_done = ok_done && inflight[0].write;
      pass    = resv.exists(m) && resv[m] == gran && !(wr_done && inflight[0].gran == gran);
      accept  = src_hready && src_htrans[1];
      e_ok    = have && inflight[0].excl && !lf && !dst_hresp;

      check_output($sformatf("rnd%0d dst_htrans", c), 32'(dst_htrans),
                   (accept && is_ex && src_hwrite && !pass) ? 32'd0 : 32'(src_htrans));
      check_output($sformatf("rnd%0d hready_resp", c), 32'(src_hready_resp),
                   lf ? 32'd1 : 32'(dst_hready_resp));
      check_output($sformatf("rnd%0d hresp", c), 32'(src_hresp), lf ? 32'd0 : 32'(dst_hresp));
      check_output($sformatf("rnd%0d hexokay", c), 32'(src_hexokay), 32'(e_ok));
      check_output($sformatf("rnd%0d dst_haddr", c), dst_haddr, src_haddr);
      check_output($sformatf("rnd%0d hrdata", c), src_hrdata, dst_hrdata);
      check_output($sformatf("rnd%0d hwdata", c), dst_hwdata, src_hwdata);
      check_output($sformatf("rnd%0d ctrl", c),
                   32'({dst_hready, dst_hwrite, dst_hsize, dst_hburst, dst_hprot, dst_hmastlock}),
                   32'({src_hready, src_hwrite, src_hsize, src_hburst, src_hprot, src_hmastlock}));

      if (ok_done && inflight[0].excl && !inflight[0].write) resv[inflight[0].mst] = inflight[0].gran;
      if (wr_done) begin
        keys.delete();
        foreach (resv[k]) if (resv[k] == inflight[0].gran) keys.push_back(k);
        foreach (keys[j]) resv.delete(keys[j]);
      end
      if (accept && is_ex && src_hwrite) resv.delete(m);
      if (src_hready) begin
        inflight.delete();
        if (accept) begin
          t.mst   = m;
          t.gran  = gran;
          t.write = src_hwrite;
          t.excl  = is_ex;
          t.lfail = is_ex && src_hwrite && !pass;
          inflight.push_back(t);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
